// File: rtl/fft_bfly_sched.sv
`default_nettype none
//==============================================================================
// Module   : fft_bfly_sched
// Brief    : In-place radix-2 DIT butterfly address scheduler with a matched
//            read-to-write delay line. Define FFT_SCHED_STALL_EN to add a
//            stall input that pauses issue while the delay line drains.
// Revision : 1.0 - initial release
//==============================================================================
module fft_bfly_sched #(
  parameter int LOG2N    = 4,
  parameter int BFLY_LAT = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
`ifdef FFT_SCHED_STALL_EN
  input  logic                       stall,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b,
  output logic [$clog2(LOG2N)-1:0]   stage
);

  localparam int c_D  = BFLY_LAT + 1;
  localparam int c_SW = $clog2(LOG2N);
  localparam int c_KW = LOG2N - 1;
  localparam int c_DW = $clog2(c_D + 1);

  localparam logic [LOG2N-1:0] c_ONE       = LOG2N'(1);
  localparam logic [c_KW-1:0]  c_KMAX      = {c_KW{1'b1}};
  localparam logic [c_SW-1:0]  c_SMAX      = c_SW'(LOG2N - 1);
  localparam logic [c_DW-1:0]  c_DMAX      = c_DW'(c_D - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_KW-1:0]   r_k;
  logic [c_SW-1:0]   r_stage;
  logic [c_DW-1:0]   r_dcnt;

  logic              w_stall;
  logic              w_issue;
  logic              w_last_k;
  logic              w_last_stage;
  logic              w_drain_end;

  logic [LOG2N-1:0]  w_k_ext;
  logic [LOG2N-1:0]  w_half;
  logic [LOG2N-1:0]  w_mask;
  logic [LOG2N-1:0]  w_addr_a;
  logic [LOG2N-1:0]  w_addr_b;
  logic [c_KW-1:0]   w_tw;

  logic [c_D-1:0]    r_dv;
  logic [LOG2N-1:0]  r_da [c_D];
  logic [LOG2N-1:0]  r_db [c_D];

`ifdef FFT_SCHED_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_issue      = (r_state == S_RUN) && !w_stall;
  assign w_last_k     = (r_k == c_KMAX);
  assign w_last_stage = (r_stage == c_SMAX);
  assign w_drain_end  = (r_state == S_DRAIN) && (r_dcnt == c_DMAX);

  // Butterfly k of stage s pairs a with a+2^s, where a inserts a 0 at bit s of k.
  assign w_k_ext  = {1'b0, r_k};
  assign w_half   = c_ONE << r_stage;
  assign w_mask   = w_half - c_ONE;
  assign w_addr_a = ((w_k_ext >> r_stage) << (int'(r_stage) + 1)) | (w_k_ext & w_mask);
  assign w_addr_b = w_addr_a + w_half;
  assign w_tw     = (r_k & w_mask[c_KW-1:0]) << (c_KW - int'(r_stage));

  //--------------------------------------------------------------------------
  // FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_last_k) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_state_nxt = w_last_stage ? S_FIN : S_RUN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Butterfly, stage and drain counters
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_k     <= '0;
        r_stage <= '0;
      end
      // k is a power-of-two counter, so it wraps to 0 after the last butterfly.
      if (w_issue) begin
        r_k <= r_k + 1'b1;
      end
      if (r_state == S_DRAIN) begin
        if (w_drain_end) begin
          r_dcnt <= '0;
          if (!w_last_stage) begin
            r_stage <= r_stage + 1'b1;
          end
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Read-to-write delay line: one RAM read cycle plus butterfly latency
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv <= '0;
      for (int i = 0; i < c_D; i++) begin
        r_da[i] <= '0;
        r_db[i] <= '0;
      end
    end else begin
      r_dv[0] <= rd_en;
      r_da[0] <= rd_addr_a;
      r_db[0] <= rd_addr_b;
      for (int i = 1; i < c_D; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_da[i] <= r_da[i-1];
        r_db[i] <= r_db[i-1];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs; read-side buses are zero whenever no read is issued
  //--------------------------------------------------------------------------
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign rd_en     = w_issue;
  assign rd_addr_a = w_issue ? w_addr_a : '0;
  assign rd_addr_b = w_issue ? w_addr_b : '0;
  assign tw_addr   = w_issue ? w_tw : '0;
  assign wr_en     = r_dv[c_D-1];
  assign wr_addr_a = r_da[c_D-1];
  assign wr_addr_b = r_db[c_D-1];
  assign stage     = r_stage;

endmodule
`default_nettype wire

// File: doc/fft_bfly_sched.md
FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of FFT length N (N = 2^LOG2N, legal range 2..10).
REQ-002 SHALL have parameter BFLY_LAT, default 6, meaning butterfly datapath latency in clk cycles from operands presented to results valid.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to run a full N-point transform.
REQ-006 SHALL have port busy, output, 1 bit: transform in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse at transform completion.
REQ-008 SHALL have port rd_en, output, 1 bit: operand read strobe to the sample RAM.
REQ-009 SHALL have ports rd_addr_a and rd_addr_b, output, LOG2N bits each: butterfly A and B operand addresses.
REQ-010 SHALL have port tw_addr, output, LOG2N-1 bits: twiddle ROM address, valid with rd_en.
REQ-011 SHALL have port wr_en, output, 1 bit: result write strobe to the sample RAM.
REQ-012 SHALL have ports wr_addr_a and wr_addr_b, output, LOG2N bits each: X and Y result addresses.
REQ-013 SHALL have port stage, output, ceil(log2(LOG2N)) bits: current stage index.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DRAIN -> (RUN | FIN) -> IDLE.
REQ-015 SHALL, in IDLE, on start=1, go to RUN with stage=0 and k=0; start SHALL be ignored in every other state.
REQ-016 SHALL, in RUN, assert rd_en once per cycle for butterfly k = 0..N/2-1 of the current stage, N/2 consecutive cycles.
REQ-017 SHALL generate, for stage s and half=2^s: rd_addr_a = ((k>>s)<<(s+1)) | (k & (half-1)); rd_addr_b = rd_addr_a + half; tw_addr = (k & (half-1)) << (LOG2N-1-s).
REQ-018 SHALL assume data is already bit-reversed in RAM (DIT, in-place); the block performs no reordering.
REQ-019 SHALL delay rd_en, rd_addr_a and rd_addr_b through a D = BFLY_LAT+1 stage shift register (1 cycle of synchronous RAM read plus BFLY_LAT), producing wr_en, wr_addr_a and wr_addr_b exactly D cycles after the matching read.
REQ-020 SHALL, after the last issue of a stage (cycle t), enter DRAIN and issue the first butterfly of stage s+1 at cycle t+D+1, so that no read precedes the last write of the prior stage.
REQ-021 SHALL, after the final stage's drain, enter FIN and pulse done at cycle t+D+1, then return to IDLE.
REQ-022 SHALL hold busy=1 from the cycle after start is accepted through the done cycle inclusive.
REQ-023 SHALL keep rd_en=0 in IDLE, DRAIN and FIN.
REQ-024 SHALL hold stage at its last value in IDLE until the next start.
REQ-025 SHALL wrap k and stage counters without overflow at the N/2-1 and LOG2N-1 boundaries.

Reset
REQ-026 SHALL, when rst=1, force the FSM to IDLE, stage=0, k=0 and all outputs to 0, and clear the delay line, so that no wr_en is emitted for butterflies issued before reset.
REQ-027 SHALL, when rst=1 coincides with start=1, give rst priority.

Configuration
REQ-028 SHALL, when FFT_SCHED_STALL_EN is defined, add input port stall (1 bit); while stall=1 in RUN, rd_en=0 and k holds, while the delay line keeps shifting; DRAIN timing is counted from the actual last issue.
REQ-029 SHALL, when FFT_SCHED_STALL_EN is undefined, have no stall port and issue on every RUN cycle.

Verification (LOG2N=3, BFLY_LAT=6, D=7, start sampled at cycle 0)
REQ-030 Stage-0 issue -> rd_en high cycles 1-4; addresses (0,1),(2,3),(4,5),(6,7); tw_addr=0 on all four.
REQ-031 Stage-1/2 addressing -> stage 1 at cycles 12-15: (0,2)/tw0, (1,3)/tw2, (4,6)/tw0, (5,7)/tw2; stage 2 at cycles 23-26: (0,4)/tw0, (1,5)/tw1, (2,6)/tw2, (3,7)/tw3.
REQ-032 Write timing -> wr_en high cycles 8-11, 19-22 and 30-33 with addresses equal to the reads 7 cycles earlier; done=1 only at cycle 34; busy=1 for cycles 1-34.
REQ-033 start pulsed at cycle 10 during the run -> ignored; the trace is identical to REQ-032.
REQ-034 rst at cycle 14 -> from cycle 15 all outputs are 0 and no wr_en occurs; a new start at cycle 20 reproduces the REQ-030 sequence shifted by 20.
REQ-035 With FFT_SCHED_STALL_EN defined, stall=1 at cycles 2-3 -> stage-0 reads at cycles 1, 4, 5, 6; the last write is at cycle 13; stage 1 begins at cycle 14.
